// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, SPI mode, SCLK divider,
// bit order and one-hot chip selects behind a start/busy/done handshake.
module spi_master_param #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NUM_CS     = 4,
    parameter  int unsigned DIV_WIDTH  = 8,
    localparam int unsigned CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int unsigned EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [EW-1:0]         edge_cnt;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;

    logic [NUM_CS-1:0]     cs_dec_c;
    logic                  half_done_c;
    logic [EW-1:0]         next_edge_c;
    logic                  do_edge_c;
    logic                  drive_c;
    logic                  sample_c;
    logic                  tx_bit_c;
    logic [DATA_WIDTH-1:0] tx_shift_c;
    logic [DATA_WIDTH-1:0] rx_shift_c;
    logic                  first_bit_c;
    logic [DATA_WIDTH-1:0] first_shift_c;

    // One-hot active-low decode; out-of-range selects assert nothing
    always_comb begin
        cs_dec_c = '1;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            if (cs_sel == CS_W'(i)) begin
                cs_dec_c[i] = 1'b0;
            end
        end
    end

    // Half-period timing, edge classification and shift-register next values
    always_comb begin
        half_done_c   = (cnt == div_q);
        next_edge_c   = edge_cnt + EW'(1);
        do_edge_c     = half_done_c &&
                        ((state == SETUP) || ((state == SHIFT) && (edge_cnt != LAST_EDGE)));
        drive_c       = cpha_q ? next_edge_c[0]
                               : (!next_edge_c[0] && (next_edge_c != LAST_EDGE));
        sample_c      = cpha_q ? !next_edge_c[0] : next_edge_c[0];
        tx_bit_c      = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
        tx_shift_c    = lsb_q ? {1'b0, tx_q[DATA_WIDTH-1:1]} : {tx_q[DATA_WIDTH-2:0], 1'b0};
        rx_shift_c    = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
        first_bit_c   = lsb_first ? data_in[0] : data_in[DATA_WIDTH-1];
        first_shift_c = lsb_first ? {1'b0, data_in[DATA_WIDTH-1:1]}
                                  : {data_in[DATA_WIDTH-2:0], 1'b0};
    end

    // Transfer FSM with registered SPI and handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_q    <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done gate keeps the completion cycle from accepting a new start
                    if (start && !done) begin
                        state    <= SETUP;
                        div_q    <= clk_div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_first;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        rx_q     <= '0;
                        busy     <= 1'b1;
                        cs_n     <= cs_dec_c;
                        sclk     <= cpol;
                        if (!cpha) begin
                            mosi <= first_bit_c;
                            tx_q <= first_shift_c;
                        end else begin
                            tx_q <= data_in;
                        end
                    end
                end
                SETUP: begin
                    if (half_done_c) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                SHIFT: begin
                    if (half_done_c) begin
                        cnt <= '0;
                        if (edge_cnt == LAST_EDGE) begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (half_done_c) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cs_n     <= '1;
                        data_out <= rx_q;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // SCLK edge: toggle, then drive or sample according to the latched mode
            if (do_edge_c) begin
                sclk     <= !sclk;
                edge_cnt <= next_edge_c;
                if (drive_c) begin
                    mosi <= tx_bit_c;
                    tx_q <= tx_shift_c;
                end
                if (sample_c) begin
                    rx_q <= rx_shift_c;
                end
            end
        end
    end

endmodule
